bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares one server bus among NUM_CLIENTS bus clients, each with the address / rq / ack / wr_ni / dataW / dataR interface.
- Round-robin arbitration. Holds the grant for one full transaction, muxes the winner's request onto the server side and routes the server ack back to the winner only.
- Sits between the client instances and the shared server; adds timeout protection against a silent server.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8).
- DATA_WIDTH, 8, data bus width.
- ADDR_WIDTH, 4, address bus width.
- TIMEOUT_CYCLES, 15, max cycles in BUSY without srv_ack before abort (1..255).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- client_rq  input  NUM_CLIENTS  per-client request.
- client_addr  input  NUM_CLIENTS*ADDR_WIDTH  flattened addresses; client i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- client_wr_ni  input  NUM_CLIENTS  per-client op select, 1 = read, 0 = write.
- client_dataW  input  NUM_CLIENTS*DATA_WIDTH  flattened write data.
- client_ack  output  NUM_CLIENTS  per-client acknowledge, one-hot or zero.
- client_dataR  output  DATA_WIDTH  read data, broadcast to all clients; valid only with that client's ack.
- srv_rq  output  1  request to server.
- srv_addr  output  ADDR_WIDTH  address of granted client.
- srv_wr_ni  output  1  op select of granted client.
- srv_dataW  output  DATA_WIDTH  write data of granted client.
- srv_ack  input  1  server acknowledge.
- srv_dataR  input  DATA_WIDTH  server read data.
- grant_id  output  $clog2(NUM_CLIENTS)  index of current/last granted client.
- busy  output  1  high in BUSY and RELEASE.
- timeout_err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async) values:
  - FSM = IDLE; srv_rq = 0; client_ack = 0; grant_id = 0; busy = 0; timeout_err = 0; timeout counter = 0.
  - Priority pointer last_grant = NUM_CLIENTS-1, so client 0 wins first.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - If any client_rq bit is set, pick the first requester searching from last_grant+1 upward, wrapping modulo NUM_CLIENTS.
  - Register it into grant_id; clear the counter; go to BUSY.
  - Otherwise stay in IDLE.
  - Latency: rq seen at edge N gives srv_rq = 1 after edge N+1 (one cycle).
- BUSY:
  - srv_rq = 1. srv_addr / srv_wr_ni / srv_dataW are a combinational mux of client[grant_id].
  - srv_ack = 1: client_ack[grant_id] = srv_ack combinationally in the same cycle, client_dataR = srv_dataR; next state RELEASE; last_grant <= grant_id.
  - srv_ack = 0: counter increments. When counter == TIMEOUT_CYCLES-1 and no ack, timeout_err pulses for 1 cycle, no client ack is issued, last_grant <= grant_id, next state RELEASE.
  - Granted client drops rq before ack: abort to RELEASE, no ack, no timeout_err, last_grant <= grant_id.
  - srv_ack and rq-drop in the same cycle: ack wins and is forwarded.
- RELEASE:
  - srv_rq = 0, all client_ack = 0, then go to IDLE unconditionally.
  - Guarantees one dead cycle between transactions, so the server sees an rq falling edge.
- Outside BUSY:
  - srv_addr, srv_wr_ni, srv_dataW still reflect client[grant_id] (no gating); only srv_rq qualifies them.
  - client_ack is forced to 0 regardless of srv_ack.
  - client_dataR = srv_dataR always.
- Throughput: minimum 3 cycles per transaction (IDLE, BUSY with immediate ack, RELEASE).
- Fairness: with all clients requesting continuously, grants rotate 0,1,2,3,0,...; worst-case wait = (NUM_CLIENTS-1) transactions.
- Reset mid-transaction: srv_rq and client_ack drop immediately (async), pointer returns to NUM_CLIENTS-1.
- grant_id is held after RELEASE until the next arbitration.

Decomposition:
- Package bus_arb_pkg holds:
  - FSM state encoding (2-bit: IDLE = 0, BUSY = 1, RELEASE = 2).
  - Helper function for grant index width.
- Sub-module rr_picker: purely combinational.
  - Inputs: request vector, last_grant.
  - Outputs: winner index, any_rq.
- FSM, counter, muxes and ack routing stay in bus_arbiter.

Test Plan:
- Single requester: client_rq = 0b0100, server acks 2 cycles after srv_rq -> srv_rq high 1 cycle after rq, grant_id = 2, srv_addr = client 2 address, client_ack = 0b0100 for exactly 1 cycle, then srv_rq = 0 for 1 cycle.
- Round-robin: client_rq = 0b1111 held, server acks immediately -> grant sequence 0,1,2,3,0; client_ack sequence 0001,0010,0100,1000; one transaction every 3 cycles.
- Read data path: client 1 issues a read (wr_ni = 1), server returns srv_dataR = 0xA5 with ack -> client_dataR = 0xA5 in the same cycle as client_ack[1] = 1; no other ack bit asserted.
- Timeout: server never acks, TIMEOUT_CYCLES = 15 -> timeout_err pulses exactly once after 15 BUSY cycles, no client_ack, the next requester is granted after RELEASE.
- Early rq drop: client 3 granted, drops rq after 1 BUSY cycle while client 0 is requesting -> abort, no ack, no timeout_err, client 0 granted next.
- Reset mid-BUSY: assert reset between edges -> srv_rq = 0 and client_ack = 0 immediately; after release with client_rq = 0b1111, client 0 is granted first.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg
//   Shared definitions for the bus arbiter slice: FSM state encoding and a
//   helper that sizes the grant index.
package bus_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Width of a client index; never narrower than one bit.
    function automatic int grant_width(input int num_clients);
        return (num_clients <= 2) ? 1 : $clog2(num_clients);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker
//   Purely combinational round-robin search. Starting one position above
//   last_grant and wrapping modulo NUM_CLIENTS, returns the first requester.
// Ports:
//   rq          in   NUM_CLIENTS  request vector
//   last_grant  in   GRANT_W      most recently served client
//   winner      out  GRANT_W      chosen client (last_grant when nobody asks)
//   any_rq      out  1            at least one request present
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    localparam int GRANT_W = grant_width(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] rq,
    input  logic [GRANT_W-1:0]     last_grant,
    output logic [GRANT_W-1:0]     winner,
    output logic                   any_rq
);

    int               cand;
    logic [GRANT_W-1:0] idx;
    logic             found;

    // Offsets 1..NUM_CLIENTS visit every client once, last_grant itself last,
    // so the client just served has the lowest priority.
    always_comb begin
        winner = last_grant;
        any_rq = |rq;
        found  = 1'b0;
        cand   = 0;
        idx    = '0;
        for (int off = 1; off <= NUM_CLIENTS; off++) begin
            cand = int'(last_grant) + off;
            if (cand >= NUM_CLIENTS) begin
                cand = cand - NUM_CLIENTS;
            end
            idx = GRANT_W'(cand);
            if (!found && rq[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares one server bus among NUM_CLIENTS clients with round-robin
//   arbitration. The grant is held for a whole transaction; the winner's
//   request is muxed to the server and the server ack is routed back to the
//   winner only. A silent server is cut off after TIMEOUT_CYCLES BUSY cycles.
// Ports:
//   clk, reset     clock (rising edge) and async active-high reset
//   client_*       flattened per-client request bus (rq/addr/wr_ni/dataW in,
//                  ack out) and broadcast read data client_dataR
//   srv_*          shared server bus (rq/addr/wr_ni/dataW out, ack/dataR in)
//   grant_id       current / last granted client
//   busy           high in BUSY and RELEASE
//   timeout_err    one-cycle pulse after a timeout abort
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 15,
    localparam int GRANT_W = grant_width(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            client_rq,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_addr,
    input  logic [NUM_CLIENTS-1:0]            client_wr_ni,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataW,
    output logic [NUM_CLIENTS-1:0]            client_ack,
    output logic [DATA_WIDTH-1:0]             client_dataR,
    output logic                              srv_rq,
    output logic [ADDR_WIDTH-1:0]             srv_addr,
    output logic                              srv_wr_ni,
    output logic [DATA_WIDTH-1:0]             srv_dataW,
    input  logic                              srv_ack,
    input  logic [DATA_WIDTH-1:0]             srv_dataR,
    output logic [GRANT_W-1:0]                grant_id,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]         state;
    logic [GRANT_W-1:0] last_grant;
    logic [GRANT_W-1:0] pick;
    logic               any_rq;
    logic [7:0]         to_cnt;
    logic               granted_rq;

    rr_picker #(
        .NUM_CLIENTS(NUM_CLIENTS)
    ) u_picker (
        .rq         (client_rq),
        .last_grant (last_grant),
        .winner     (pick),
        .any_rq     (any_rq)
    );

    // Priority inside BUSY: server ack, then requester withdrawal, then timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            last_grant  <= GRANT_W'(NUM_CLIENTS - 1);
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_rq) begin
                        grant_id <= pick;
                        to_cnt   <= '0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (srv_ack || !granted_rq) begin
                        last_grant <= grant_id;
                        state      <= ST_RELEASE;
                    end else if (to_cnt == TO_LAST) begin
                        last_grant  <= grant_id;
                        timeout_err <= 1'b1;
                        state       <= ST_RELEASE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                ST_RELEASE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Server-side fields follow grant_id in every state; srv_rq alone qualifies
    // them. The ack path is combinational so the winner sees it in the same
    // cycle the server raises it.
    always_comb begin
        srv_addr   = '0;
        srv_wr_ni  = 1'b0;
        srv_dataW  = '0;
        granted_rq = 1'b0;
        client_ack = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_id == GRANT_W'(i)) begin
                srv_addr      = client_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                srv_wr_ni     = client_wr_ni[i];
                srv_dataW     = client_dataW[i*DATA_WIDTH +: DATA_WIDTH];
                granted_rq    = client_rq[i];
                client_ack[i] = (state == ST_BUSY) && srv_ack;
            end
        end
    end

    assign srv_rq       = (state == ST_BUSY);
    assign busy         = (state != ST_IDLE);
    assign client_dataR = srv_dataR;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Randomized scoreboard bench for bus_arbiter. The stimulus process predicts
//   each transaction (winner, captured fields, outcome, length) and queues it;
//   a separate monitor reconstructs each transaction from the bus and compares.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int T  = 15;
    localparam int GW = 2;

    localparam int K_ACK     = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_DROP    = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    client_rq;
    logic [N*AW-1:0] client_addr;
    logic [N-1:0]    client_wr_ni;
    logic [N*DW-1:0] client_dataW;
    logic [N-1:0]    client_ack;
    logic [DW-1:0]   client_dataR;
    logic            srv_rq;
    logic [AW-1:0]   srv_addr;
    logic            srv_wr_ni;
    logic [DW-1:0]   srv_dataW;
    logic            srv_ack;
    logic [DW-1:0]   srv_dataR;
    logic [GW-1:0]   grant_id;
    logic            busy;
    logic            timeout_err;

    bus_arbiter #(
        .NUM_CLIENTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset),
        .client_rq(client_rq), .client_addr(client_addr),
        .client_wr_ni(client_wr_ni), .client_dataW(client_dataW),
        .client_ack(client_ack), .client_dataR(client_dataR),
        .srv_rq(srv_rq), .srv_addr(srv_addr), .srv_wr_ni(srv_wr_ni),
        .srv_dataW(srv_dataW), .srv_ack(srv_ack), .srv_dataR(srv_dataR),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int winner;
        int addr;
        int wr;
        int dataW;
        int issueCycle;
        int kind;
        int len;
        int dataR;
    } txn_t;

    txn_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    int   modelLast  = N - 1;
    int   srvAckDelay = -1;
    int   srvDataVal  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference arbitration: first requester above the last served, wrapping.
    function automatic int pickWinner(input logic [N-1:0] mask);
        for (int off = 1; off <= N; off++) begin
            int idx;
            idx = (modelLast + off) % N;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    // Server model: acks on BUSY cycle srvAckDelay+1, never if negative.
    // Outside a transaction it toggles srv_ack randomly to prove gating.
    initial begin
        int srvCnt;
        srvCnt    = 0;
        srv_ack   = 1'b0;
        srv_dataR = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                srvCnt  = 0;
                srv_ack = 1'b0;
            end else if (srv_rq) begin
                srv_ack   = (srvAckDelay >= 0) && (srvCnt == srvAckDelay);
                srv_dataR = srv_ack ? DW'(srvDataVal) : DW'($urandom);
                srvCnt++;
            end else begin
                srvCnt    = 0;
                srv_ack   = 1'($urandom_range(0, 1));
                srv_dataR = DW'($urandom);
            end
        end
    end

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("waitIdle", 1, 0);
    endtask

    task automatic randomizeClients();
        for (int i = 0; i < N; i++) begin
            client_addr[i*AW +: AW]  = AW'($urandom);
            client_dataW[i*DW +: DW] = DW'($urandom);
            client_wr_ni[i]          = 1'($urandom_range(0, 1));
        end
    endtask

    // Issues one transaction from IDLE; dropAt = BUSY cycle after which the
    // winner withdraws (0 = never), ackDelay < 0 = server silent.
    task automatic applyStimulus(input logic [N-1:0] mask, input int ackDelay,
                                 input int dropAt, input int dataR);
        txn_t e;
        int   w, ackC, dropC, busyN, n;
        bit   seenHigh;
        w            = pickWinner(mask);
        client_rq    = mask;
        e.winner     = w;
        e.addr       = int'(client_addr[w*AW +: AW]);
        e.wr         = int'(client_wr_ni[w]);
        e.dataW      = int'(client_dataW[w*DW +: DW]);
        e.issueCycle = cycle;
        e.dataR      = dataR & 8'hFF;
        ackC  = (ackDelay >= 0) ? ackDelay + 1 : 1000;
        dropC = (dropAt > 0) ? dropAt : 1000;
        if (ackC <= dropC && ackC <= T) begin
            e.kind = K_ACK;     e.len = ackC;
        end else if (dropC <= T) begin
            e.kind = K_DROP;    e.len = dropC;
        end else begin
            e.kind = K_TIMEOUT; e.len = T;
        end
        modelLast   = w;
        srvAckDelay = ackDelay;
        srvDataVal  = dataR;
        expQ.push_back(e);
        busyN    = 0;
        seenHigh = 0;
        n        = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (srv_rq) begin
                seenHigh = 1;
                busyN++;
                if (dropAt > 0 && busyN == dropAt) client_rq[w] = 1'b0;
            end else if (seenHigh) begin
                break;
            end
        end
        client_rq = '0;
        if (!seenHigh || n >= 200) checkOutput("txnDone", 0, 1);
    endtask

    // All clients request continuously with an immediately acking server.
    task automatic runRoundRobin(input int count);
        txn_t e;
        int   c, falls, n;
        bit   seenHigh;
        randomizeClients();
        client_rq   = '1;
        srvAckDelay = 0;
        srvDataVal  = int'($urandom_range(0, 255));
        c = cycle;
        for (int i = 0; i < count; i++) begin
            e.winner     = pickWinner('1);
            e.addr       = int'(client_addr[e.winner*AW +: AW]);
            e.wr         = int'(client_wr_ni[e.winner]);
            e.dataW      = int'(client_dataW[e.winner*DW +: DW]);
            e.issueCycle = c + 3 * i;
            e.kind       = K_ACK;
            e.len        = 1;
            e.dataR      = srvDataVal;
            modelLast    = e.winner;
            expQ.push_back(e);
        end
        falls = 0;
        seenHigh = 0;
        n = 0;
        while (falls < count && n < 3 * count + 20) begin
            @(negedge clk);
            n++;
            if (srv_rq) seenHigh = 1;
            else if (seenHigh) begin
                falls++;
                seenHigh = 0;
            end
        end
        client_rq = '0;
        if (falls < count) checkOutput("rrDone", falls, count);
    endtask

    // Monitor: rebuilds each transaction from srv_rq high..low and scores it.
    bit   inTx = 0;
    int   mStart, mGid, mAddr, mWr, mDw, mAcks, mLen, mAckVec, mDataR, mToBusy;
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                inTx = 0;
            end else if (srv_rq) begin
                if (!inTx) begin
                    inTx    = 1;
                    mStart  = cycle;
                    mGid    = int'(grant_id);
                    mAddr   = int'(srv_addr);
                    mWr     = int'(srv_wr_ni);
                    mDw     = int'(srv_dataW);
                    mAcks   = 0;
                    mLen    = 0;
                    mAckVec = 0;
                    mDataR  = 0;
                    mToBusy = 0;
                end
                mLen++;
                if (client_ack != '0) begin
                    mAcks++;
                    mAckVec = int'(client_ack);
                    mDataR  = int'(client_dataR);
                end
                if (timeout_err) mToBusy++;
            end else if (inTx) begin
                inTx = 0;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedTxn", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("grantId", mGid, e.winner);
                    checkOutput("srvAddr", mAddr, e.addr);
                    checkOutput("srvWrNi", mWr, e.wr);
                    checkOutput("srvDataW", mDw, e.dataW);
                    checkOutput("rqLatency", mStart, e.issueCycle + 1);
                    checkOutput("busyLen", mLen, e.len);
                    checkOutput("ackCount", mAcks, (e.kind == K_ACK) ? 1 : 0);
                    checkOutput("timeoutPulse", int'(timeout_err), (e.kind == K_TIMEOUT) ? 1 : 0);
                    checkOutput("timeoutInBusy", mToBusy, 0);
                    checkOutput("releaseAck", int'(client_ack), 0);
                    checkOutput("grantHeld", int'(grant_id), e.winner);
                    if (e.kind == K_ACK) begin
                        checkOutput("ackVector", mAckVec, 1 << e.winner);
                        checkOutput("readData", mDataR, e.dataR);
                    end
                end
            end else begin
                checkOutput("idleAck", int'(client_ack), 0);
                checkOutput("idleTimeout", int'(timeout_err), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r, d, k;
        logic [N-1:0] m;
        reset        = 1'b1;
        client_rq    = '0;
        client_addr  = '0;
        client_wr_ni = '0;
        client_dataW = '0;
        #12;
        checkOutput("rstSrvRq", int'(srv_rq), 0);
        checkOutput("rstAck", int'(client_ack), 0);
        checkOutput("rstGrant", int'(grant_id), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstTimeout", int'(timeout_err), 0);
        @(negedge clk);
        reset = 1'b0;

        // Rotation from reset: 0,1,2,3,0 one transaction every 3 cycles.
        waitIdle();
        runRoundRobin(5);

        // Single requester, server acks two cycles after srv_rq.
        waitIdle();
        randomizeClients();
        applyStimulus(4'b0100, 2, 0, int'($urandom_range(0, 255)));

        // Read by client 1 returning 0xA5.
        waitIdle();
        randomizeClients();
        client_wr_ni[1] = 1'b1;
        applyStimulus(4'b0010, 0, 0, 8'hA5);

        // Silent server, then the next requester gets the bus.
        waitIdle();
        randomizeClients();
        applyStimulus(4'b0011, -1, 0, 0);
        waitIdle();
        randomizeClients();
        applyStimulus(4'b0011, 1, 0, int'($urandom_range(0, 255)));

        // Client 3 withdraws after one BUSY cycle; client 0 waits.
        waitIdle();
        randomizeClients();
        applyStimulus(4'b1001, -1, 1, 0);
        waitIdle();
        randomizeClients();
        applyStimulus(4'b0001, 0, 0, int'($urandom_range(0, 255)));

        // Ack and withdrawal in the same cycle: ack is forwarded.
        waitIdle();
        randomizeClients();
        applyStimulus(4'b0100, 1, 2, int'($urandom_range(0, 255)));

        // Reset in the middle of BUSY.
        waitIdle();
        randomizeClients();
        client_rq   = 4'b0100;
        srvAckDelay = -1;
        @(negedge clk);
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midRstSrvRq", int'(srv_rq), 0);
        checkOutput("midRstAck", int'(client_ack), 0);
        checkOutput("midRstBusy", int'(busy), 0);
        checkOutput("midRstGrant", int'(grant_id), 0);
        @(negedge clk);
        client_rq = '0;
        @(negedge clk);
        reset     = 1'b0;
        modelLast = N - 1;
        waitIdle();
        randomizeClients();
        applyStimulus(4'b1111, 0, 0, int'($urandom_range(0, 255)));

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            waitIdle();
            randomizeClients();
            m = N'($urandom_range(1, (1 << N) - 1));
            r = int'($urandom_range(0, 9));
            d = int'($urandom_range(0, 3));
            k = int'($urandom_range(1, 3));
            if (r <= 5)      applyStimulus(m, d, 0, int'($urandom_range(0, 255)));
            else if (r <= 7) applyStimulus(m, -1, k, 0);
            else if (r == 8) applyStimulus(m, -1, 0, 0);
            else             applyStimulus(m, d, d + 1, int'($urandom_range(0, 255)));
        end

        repeat (4) @(negedge clk);
        checkOutput("queueEmpty", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
